if_fetch_unit: RTL

//  Instruction fetch front end; the producer side of the decode interface.

---
 rtl/fetch_pkg.sv | 18 +
 rtl/if_fetch_buf.sv | 62 ++++++
 rtl/if_fetch_unit.sv | 137 +++++++++++++
 3 files changed

// File: rtl/fetch_pkg.sv
// Shared constants and helpers for the instruction fetch front end.
package fetch_pkg;

  localparam int XLEN = 32;
  localparam int ILEN = 32;
  localparam logic [ILEN-1:0] INSTR_NOP = 32'h0000_0013;
  localparam int PC_STEP = 4;

  function automatic int clog2(input int value);
    int r;
    r = 0;
    while ((1 << r) < value) begin
      r++;
    end
    return r;
  endfunction

endpackage

// File: rtl/if_fetch_buf.sv
// Synchronous FIFO holding fetched {pc, instr} entries; flush empties it in one cycle.
module if_fetch_buf
  import fetch_pkg::*;
#(
  parameter int WIDTH = 64,
  parameter int DEPTH = 4,
  parameter int CW    = clog2(DEPTH + 1)
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             push_i,
  input  logic             pop_i,
  input  logic             flush_i,
  input  logic [WIDTH-1:0] wdata_i,
  output logic [WIDTH-1:0] rdata_o,
  output logic             full_o,
  output logic             empty_o,
  output logic [CW-1:0]    count_o
);

  localparam int AW = clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
  logic [CW-1:0]    count_q;
  logic             do_push, do_pop;

  assign full_o  = (count_q == CW'(DEPTH));
  assign empty_o = (count_q == '0);
  assign count_o = count_q;
  assign rdata_o = mem_q[rd_ptr_q];

  // A push into a full buffer is only legal when the head leaves in the same cycle.
  assign do_push = push_i & (~full_o | pop_i);
  assign do_pop  = pop_i & ~empty_o;

  always_ff @(posedge clk_i) begin
    if (do_push) begin
      mem_q[wr_ptr_q] <= wdata_i;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i || flush_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) begin
        wr_ptr_q <= wr_ptr_q + AW'(1);
      end
      if (do_pop) begin
        rd_ptr_q <= rd_ptr_q + AW'(1);
      end
      count_q <= count_q + CW'(do_push) - CW'(do_pop);
    end
  end

  a_no_overflow: assert property (@(posedge clk_i) disable iff (rst_i)
    !(push_i && full_o && !pop_i && !flush_i));

endmodule

// File: rtl/if_fetch_unit.sv
// Instruction fetch front end: credit-limited imem requests, response queue, decode handshake.
// Optional misaligned-redirect halt is compiled in with IF_MISALIGN_CHECK_EN.
module if_fetch_unit #(
  parameter int              XLEN     = fetch_pkg::XLEN,
  parameter int              DEPTH    = 4,
  parameter logic [XLEN-1:0] RESET_PC = '0
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     redirect_valid,
  input  logic [XLEN-1:0]          redirect_pc,
  output logic                     imem_req_valid,
  input  logic                     imem_req_ready,
  output logic [XLEN-1:0]          imem_req_addr,
  input  logic                     imem_rsp_valid,
  input  logic [fetch_pkg::ILEN-1:0] imem_rsp_data,
  output logic                     id_valid,
  input  logic                     id_ready,
  output logic [fetch_pkg::ILEN-1:0] id_instr,
  output logic [XLEN-1:0]          id_pc
`ifdef IF_MISALIGN_CHECK_EN
  ,output logic                    id_misalign
`endif
);

  import fetch_pkg::*;

  localparam int             CW      = clog2(DEPTH + 1);
  localparam int             EW      = XLEN + ILEN;
  localparam logic [CW:0]    CREDITS = (CW + 1)'(DEPTH);
  localparam logic [XLEN-1:0] STEP   = XLEN'(PC_STEP);

  logic [XLEN-1:0] fetch_pc_q, rsp_pc_q, redir_pc;
  logic [CW-1:0]   outstanding_q, outstanding_d, drop_q, buf_count;
  logic [CW:0]     credit_used;
  logic [EW-1:0]   buf_head;
  logic            buf_full, buf_empty;
  logic            req_fire, push, pop, halt_active;
  logic [XLEN-1:0] head_pc;
  logic [ILEN-1:0] head_instr;

  assign redir_pc    = {redirect_pc[XLEN-1:2], 2'b00};
  assign credit_used = {1'b0, outstanding_q} + {1'b0, buf_count};

  assign imem_req_valid = ~rst & ~redirect_valid & ~halt_active & (credit_used < CREDITS);
  assign imem_req_addr  = fetch_pc_q;
  assign req_fire       = imem_req_valid & imem_req_ready;

  // A response landing in a redirect cycle is stale and counts against outstanding only.
  assign push = ~rst & imem_rsp_valid & ~redirect_valid & (drop_q == '0);

  assign id_valid = ~rst & ~redirect_valid & (halt_active | ~buf_empty);
  assign pop      = id_valid & id_ready & ~halt_active;

  assign outstanding_d = outstanding_q + CW'(req_fire) - CW'(imem_rsp_valid);

  assign head_pc    = buf_head[EW-1:ILEN];
  assign head_instr = buf_head[ILEN-1:0];

  if_fetch_buf #(
    .WIDTH (EW),
    .DEPTH (DEPTH),
    .CW    (CW)
  ) u_buf (
    .clk_i   (clk),
    .rst_i   (rst),
    .push_i  (push),
    .pop_i   (pop),
    .flush_i (redirect_valid),
    .wdata_i ({rsp_pc_q, imem_rsp_data}),
    .rdata_o (buf_head),
    .full_o  (buf_full),
    .empty_o (buf_empty),
    .count_o (buf_count)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      fetch_pc_q    <= RESET_PC;
      rsp_pc_q      <= RESET_PC;
      outstanding_q <= '0;
      drop_q        <= '0;
    end else begin
      outstanding_q <= outstanding_d;
      if (redirect_valid) begin
        fetch_pc_q <= redir_pc;
        rsp_pc_q   <= redir_pc;
        drop_q     <= outstanding_d;
      end else begin
        if (req_fire) begin
          fetch_pc_q <= fetch_pc_q + STEP;
        end
        if (imem_rsp_valid) begin
          if (drop_q != '0) begin
            drop_q <= drop_q - CW'(1);
          end else begin
            rsp_pc_q <= rsp_pc_q + STEP;
          end
        end
      end
    end
  end

`ifdef IF_MISALIGN_CHECK_EN
  logic            halt_q;
  logic [XLEN-1:0] halt_pc_q;

  // Sticky until a later aligned redirect; the halted slot presents a NOP tagged misaligned.
  always_ff @(posedge clk) begin
    if (rst) begin
      halt_q    <= 1'b0;
      halt_pc_q <= '0;
    end else if (redirect_valid) begin
      halt_q    <= |redirect_pc[1:0];
      halt_pc_q <= redirect_pc;
    end
  end

  assign halt_active = halt_q;
  assign id_misalign = id_valid & halt_q;
  assign id_pc       = halt_q ? halt_pc_q : head_pc;
  assign id_instr    = halt_q ? INSTR_NOP : head_instr;
`else
  logic unused_redirect_lsb;

  assign unused_redirect_lsb = ^redirect_pc[1:0];
  assign halt_active         = 1'b0;
  assign id_pc               = head_pc;
  assign id_instr            = head_instr;
`endif

  a_rsp_has_req: assert property (@(posedge clk) disable iff (rst)
    imem_rsp_valid |-> (outstanding_q != '0));
  a_credit_push: assert property (@(posedge clk) disable iff (rst)
    !(push && buf_full && !pop));

endmodule
